// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the packet-aware command stream arbiter.
package cmd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0;

    // Index width for S_COUNT sources; never narrower than one bit.
    function automatic int grant_width(input int s_count);
        return (s_count > 1) ? $clog2(s_count) : 1;
    endfunction

endpackage

// File: rtl/cmd_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_pick #(
    parameter int S_COUNT = 2,
    parameter int GRANT_W = 1
) (
    input  logic [S_COUNT-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] winner,
    output logic               any_req
);

    logic [2*S_COUNT-1:0] req_dbl;
    logic [S_COUNT-1:0]   req_rot;
    int                   offset;
    int                   pos;

    // Rotating a doubled copy puts last_grant+1 at bit 0, so priority is simply lowest bit.
    assign req_dbl = {req, req};
    assign req_rot = S_COUNT'(req_dbl >> (int'(last_grant) + 1));
    assign any_req = |req;

    always_comb begin
        offset = 0;
        for (int j = S_COUNT - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = j;
            end
        end
        pos = int'(last_grant) + 1 + offset;
        if (pos >= S_COUNT) begin
            pos = pos - S_COUNT;
        end
        winner = GRANT_W'(pos);
    end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Packet-aware round-robin arbiter sharing one AXIS command bus between S_COUNT hosts.
// Optional mid-packet stall timeout with NOP terminator and drain: define ARB_TIMEOUT_EN.
module cmd_stream_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int S_COUNT        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          aclk,
    input  logic                          rst,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          grant_valid,
    output logic [$clog2(S_COUNT)-1:0]    grant_idx,
    output logic                          timeout_err
);

    localparam int GRANT_W = grant_width(S_COUNT);

    arb_state_e            state_reg;
    logic [GRANT_W-1:0]    grant_idx_reg;
    logic [GRANT_W-1:0]    last_grant_reg;
    logic [GRANT_W-1:0]    pick_idx;
    logic                  any_req;
    logic                  grant_valid_reg;
    logic                  m_valid_reg;
    logic                  m_last_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic [DATA_WIDTH-1:0] src_data [S_COUNT];
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  out_free;
    logic                  port_open;
    logic                  accept;

    genvar gi;
    generate
        for (gi = 0; gi < S_COUNT; gi++) begin : g_src
            assign src_data[gi]      = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_axis_tready[gi] = port_open && (grant_idx_reg == GRANT_W'(gi));
        end
    endgenerate

    rr_pick #(
        .S_COUNT (S_COUNT),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req        (s_axis_tvalid),
        .last_grant (last_grant_reg),
        .winner     (pick_idx),
        .any_req    (any_req)
    );

    assign sel_valid = s_axis_tvalid[grant_idx_reg];
    assign sel_last  = s_axis_tlast[grant_idx_reg];
    assign sel_data  = src_data[grant_idx_reg];
    assign out_free  = !m_valid_reg || m_axis_tready;
    assign accept    = (state_reg == GRANT) && sel_valid && out_free;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_reg;
    logic        timeout_err_reg;
    logic        fire;

    // Fire only on a stalled cycle with a free output slot, so the NOP never overwrites a beat.
    assign fire        = (state_reg == GRANT) && !sel_valid && out_free && (stall_cnt_reg == STALL_LIMIT);
    assign port_open   = ((state_reg == GRANT) && out_free) || (state_reg == DRAIN);
    assign timeout_err = timeout_err_reg;
`else
    assign port_open   = (state_reg == GRANT) && out_free;
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_idx_reg   <= '0;
            last_grant_reg  <= GRANT_W'(S_COUNT - 1);
            grant_valid_reg <= 1'b0;
            m_valid_reg     <= 1'b0;
            m_last_reg      <= 1'b0;
            m_data_reg      <= DATA_WIDTH'(NOP_WORD);
`ifdef ARB_TIMEOUT_EN
            stall_cnt_reg   <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            if (accept) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= sel_data;
                m_last_reg  <= sel_last;
            end else if (m_axis_tready) begin
                m_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_idx_reg   <= pick_idx;
                        grant_valid_reg <= 1'b1;
                        state_reg       <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept && sel_last) begin
                        last_grant_reg  <= grant_idx_reg;
                        grant_valid_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                DRAIN: begin
                    if (sel_valid && sel_last) begin
                        last_grant_reg  <= grant_idx_reg;
                        grant_valid_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase

`ifdef ARB_TIMEOUT_EN
            timeout_err_reg <= 1'b0;
            if (state_reg != GRANT || accept || fire) begin
                stall_cnt_reg <= '0;
            end else if (!sel_valid && stall_cnt_reg != STALL_LIMIT) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            // NOP terminator closes the partial packet for the parser; the rest is drained.
            if (fire) begin
                timeout_err_reg <= 1'b1;
                m_valid_reg     <= 1'b1;
                m_last_reg      <= 1'b1;
                m_data_reg      <= DATA_WIDTH'(NOP_WORD);
                state_reg       <= DRAIN;
            end
`endif
        end
    end

    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tlast  = m_last_reg;
    assign m_axis_tdata  = m_data_reg;
    assign grant_valid   = grant_valid_reg;
    assign grant_idx     = grant_idx_reg;

endmodule
